// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide sequencer owning the HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (WIDTH+2 cycles each) and MTHI/MTLO (single cycle, in IDLE).
// Optional macro MULT_DIV_EARLY_OUT_EN: multiplies with a zero operand and divides by zero
// bypass RUN/FIX and finish in DONE one cycle after the start.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   mcand;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   a_raw;     // unmodified dividend, needed for the divide-by-zero result
    logic               is_div;
    logic               neg_q;     // negate product / quotient in FIX
    logic               neg_r;     // negate remainder in FIX
    logic               div_zero;

    // op[2]=0 selects mult/div, op[1] selects divide, op[0]=0 selects signed
    logic             arith_go;
    logic             sgn;
    logic             early;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    assign arith_go = start && !op[2];
    assign sgn      = !op[0];

`ifdef MULT_DIV_EARLY_OUT_EN
    assign early = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
    assign early = 1'b0;
`endif

    // Operand magnitudes for signed ops; 0x80000000 maps onto itself, which is the right magnitude
    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    end

    // One iteration of shift-add multiply and of restoring shift-subtract divide
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; mult/div issue only from IDLE, RUN lasts WIDTH cycles
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (arith_go) state_nxt = early ? DONE : RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end else if (arith_go) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_q    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= sgn && a[WIDTH-1];
                        a_raw    <= a;
                        div_zero <= op[1] && (b == '0);
                        if (op[1]) begin
                            mcand <= b_mag;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            mcand <= a_mag;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                        end
                        if (early) begin
                            hi <= op[1] ? a : '0;
                            lo <= op[1] ? '1 : '0;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        if (!trial[WIDTH])
                            acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end else if (acc[0]) begin
                        acc <= {add_sum, acc[WIDTH-1:1]};
                    end else begin
                        acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                            lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        end
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, busy window, signed/unsigned results,
// divide-by-zero, overflow, MTHI/MTLO, ignored starts and mid-operation reset.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

`ifdef MULT_DIV_EARLY_OUT_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 34;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, wait for done (bounded), check latency, busy window and result
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int nb;
        @(negedge clk); start = 1'b1; op = o; a = x; b = y;
        @(negedge clk); start = 1'b0;
        n = 1; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busycyc"}, 64'(nb), 64'(lat - 1));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;

        run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'b011, 32'd100, 32'd7, 34, 32'd2, 32'd14);

        // MTHI presented during DONE must be ignored
        start = 1'b1; op = 3'b100; a = 32'h0000_FFFF;
        @(negedge clk); start = 1'b0;
        chk("done_start_ignored_hi", 64'(hi), 64'(2));

        run_op("divu_zero", 3'b011, 32'd100, 32'd0, LAT_Z, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF9, 32'd0, LAT_Z, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
        run_op("mult_zero", 3'b000, 32'd0, 32'd5, LAT_Z, 32'h0, 32'h0);
        run_op("mult_negneg", 3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 32'h0, 32'd6);

        // No-op opcode: nothing starts, nothing written
        @(negedge clk); start = 1'b1; op = 3'b110; a = 32'hAAAA_AAAA; b = 32'd3;
        @(negedge clk); start = 1'b0;
        chk("noop_busy", 64'(busy), 64'(0));
        chk("noop_lo", 64'(lo), 64'(6));

        // MTHI in IDLE
        start = 1'b1; op = 3'b100; a = 32'h1234_5678;
        @(negedge clk); start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_busy", 64'(busy), 64'(0));
        chk("mthi_done", 64'(done), 64'(0));

        // MULT 6*7 with MTLO and a second MULT presented while busy
        start = 1'b1; op = 3'b000; a = 32'd6; b = 32'd7;
        @(negedge clk);
        chk("mul2_busy1", 64'(busy), 64'(1));
        op = 3'b101; a = 32'hDEAD_BEEF;
        @(negedge clk);
        op = 3'b000; a = 32'd1; b = 32'd1;
        @(negedge clk); start = 1'b0;
        chk("mul2_hi_hold", 64'(hi), 64'h1234_5678);
        chk("mul2_lo_hold", 64'(lo), 64'(6));
        begin
            int n;
            n = 3;
            while (!done && n < 100) begin @(negedge clk); n++; end
            chk("mul2_lat", 64'(n), 64'(34));
        end
        chk("mul2_lo", 64'(lo), 64'(42));
        chk("mul2_hi", 64'(hi), 64'(0));
        @(negedge clk);
        chk("mul2_idle", 64'(busy), 64'(0));

        // DIV interrupted by reset at cycle 10
        run_op("pre_mthi_dummy", 3'b001, 32'd9, 32'd9, 34, 32'd0, 32'd81);
        @(negedge clk); start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst_mid_busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_hi", 64'(hi), 64'(0));
        chk("rst_mid_lo", 64'(lo), 64'(0));
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                if (done || busy) seen++;
                @(negedge clk);
            end
            chk("rst_mid_quiet", 64'(seen), 64'(0));
        end
        run_op("multu_after_rst", 3'b001, 32'd3, 32'd4, 34, 32'd0, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
